// File: rtl/alert_ping_scheduler.sv
// Round-robin liveness pinger for alert receivers: waits an LFSR-derived gap, requests a ping
// from the next enabled channel and flags a channel that does not answer within the timeout.
//
// state | meaning
// IDLE  | scheduler disabled, no request outstanding
// WAIT  | counting down the pseudo-random gap before the next ping
// PING  | request held on channel sel_q, timeout counter running
module alert_ping_scheduler #(
  parameter int unsigned NumAlerts = 4,
  parameter int unsigned WaitCntW  = 16,
  parameter int unsigned TimeoutW  = 16,
  parameter logic [15:0] LfsrSeed  = 16'hACE1,
  localparam int unsigned IdxW     = (NumAlerts > 1) ? $clog2(NumAlerts) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [WaitCntW-1:0]  wait_mask_i,
  input  logic [TimeoutW-1:0]  timeout_cyc_i,
  input  logic [NumAlerts-1:0] chan_en_i,
  input  logic [NumAlerts-1:0] ping_ok_i,
  output logic [NumAlerts-1:0] ping_req_o,
  output logic                 ping_fail_o,
  output logic [IdxW-1:0]      ping_fail_idx_o,
  output logic                 busy_o
);

  localparam int NA = int'(NumAlerts);
  localparam int unsigned LoadW = (WaitCntW < 16) ? WaitCntW : 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_PING = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [15:0]          wait_cnt_q, wait_cnt_d;
  logic [TimeoutW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]      sel_q, sel_d;
  logic [NumAlerts-1:0] req_q, req_d;
  logic                 fail_q, fail_d;
  logic [IdxW-1:0]      fail_idx_q, fail_idx_d;
  logic                 busy_q, busy_d;

  logic [15:0]          lfsr_next;
  logic [15:0]          wait_load;
  logic [IdxW-1:0]      sel_next;
  logic [IdxW-1:0]      sel_inc;
  int                   cand;

  assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  // Wider wait masks only see the 16 LFSR bits; anything above is loaded as zero.
  always_comb begin
    wait_load = '0;
    wait_load[LoadW-1:0] = lfsr_q[LoadW-1:0] & wait_mask_i[LoadW-1:0];
  end

  // Lowest offset from rr_ptr wins, so iterate from the far end down.
  always_comb begin
    sel_next = rr_ptr_q;
    cand     = 0;
    for (int k = NA - 1; k >= 0; k--) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NA) cand = cand - NA;
      if (chan_en_i[IdxW'(cand)]) sel_next = IdxW'(cand);
    end
  end

  assign sel_inc = (sel_q == IdxW'(NumAlerts - 1)) ? '0 : sel_q + IdxW'(1);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    sel_d      = sel_q;
    req_d      = req_q;
    fail_d     = 1'b0;
    fail_idx_d = fail_idx_q;
    lfsr_d     = en_i ? lfsr_next : lfsr_q;

    if (!en_i) begin
      state_d = ST_IDLE;
      req_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d    = ST_WAIT;
          wait_cnt_d = wait_load;
        end
        ST_WAIT: begin
          if (wait_cnt_q != 16'd0) begin
            wait_cnt_d = wait_cnt_q - 16'd1;
          end else if (chan_en_i == '0) begin
            wait_cnt_d = wait_load;
          end else begin
            state_d         = ST_PING;
            sel_d           = sel_next;
            tmo_cnt_d       = '0;
            req_d           = '0;
            req_d[sel_next] = 1'b1;
          end
        end
        ST_PING: begin
          if (ping_ok_i[sel_q]) begin
            state_d    = ST_WAIT;
            req_d      = '0;
            rr_ptr_d   = sel_inc;
            wait_cnt_d = wait_load;
          end else if (tmo_cnt_q >= timeout_cyc_i) begin
            state_d    = ST_WAIT;
            req_d      = '0;
            rr_ptr_d   = sel_inc;
            wait_cnt_d = wait_load;
            fail_d     = 1'b1;
            fail_idx_d = sel_q;
          end else if (tmo_cnt_q != {TimeoutW{1'b1}}) begin
            tmo_cnt_d = tmo_cnt_q + TimeoutW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          req_d   = '0;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= LfsrSeed;
      wait_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      rr_ptr_q   <= '0;
      sel_q      <= '0;
      req_q      <= '0;
      fail_q     <= 1'b0;
      fail_idx_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      wait_cnt_q <= wait_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      sel_q      <= sel_d;
      req_q      <= req_d;
      fail_q     <= fail_d;
      fail_idx_q <= fail_idx_d;
      busy_q     <= busy_d;
    end
  end

  assign ping_req_o      = req_q;
  assign ping_fail_o     = fail_q;
  assign ping_fail_idx_o = fail_idx_q;
  assign busy_o          = busy_q;

endmodule

// File: tb/tb_alert_ping_scheduler.sv
// Bench for alert_ping_scheduler: directed scenarios plus randomized traffic, all checked
// against a ping-level reference model (gap countdown, request age, round-robin pointer).
module tb_alert_ping_scheduler;
  localparam int N = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic [15:0] wait_mask_i;
  logic [15:0] timeout_cyc_i;
  logic [3:0]  chan_en_i;
  logic [3:0]  ping_ok_i;
  logic [3:0]  ping_req_o;
  logic        ping_fail_o;
  logic [1:0]  ping_fail_idx_o;
  logic        busy_o;

  alert_ping_scheduler #(
    .NumAlerts(4), .WaitCntW(16), .TimeoutW(16), .LfsrSeed(16'hACE1)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .wait_mask_i(wait_mask_i),
    .timeout_cyc_i(timeout_cyc_i), .chan_en_i(chan_en_i), .ping_ok_i(ping_ok_i),
    .ping_req_o(ping_req_o), .ping_fail_o(ping_fail_o),
    .ping_fail_idx_o(ping_fail_idx_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: lfsr, rr pointer, pending gap, channel being pinged (-1 none), request age
  logic [15:0] m_lfsr;
  int          m_rr, m_chan, m_gap, m_age, m_fidx;
  bit          m_active, m_fail;

  logic [3:0]  seq_q[$];
  logic [3:0]  prev_req;
  bit          prev_fail;
  int          gap_len;
  bit          gap_chk;
  int          fails_seen;
  int          last_fidx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit bit_of(input logic [3:0] v, input int i);
    return ((v >> i) & 4'h1) != 4'h0;
  endfunction

  task automatic model_reset();
    m_lfsr = 16'hACE1; m_rr = 0; m_chan = -1; m_gap = 0; m_age = 0;
    m_fidx = 0; m_active = 0; m_fail = 0;
  endtask

  task automatic model_step(input bit en, input logic [15:0] mask, input logic [15:0] tmo,
                            input logic [3:0] ce, input logic [3:0] ok);
    int  load;
    bit  done;
    load   = int'(m_lfsr & mask);
    m_fail = 0;
    done   = 0;
    if (!en) begin
      m_active = 0;
      m_chan   = -1;
    end else if (!m_active) begin
      m_active = 1;
      m_gap    = load;
    end else if (m_chan < 0) begin
      if (m_gap > 0) m_gap--;
      else if (ce == 4'h0) m_gap = load;
      else begin
        for (int k = N - 1; k >= 0; k--)
          if (bit_of(ce, (m_rr + k) % N)) m_chan = (m_rr + k) % N;
        m_age = 0;
      end
    end else begin
      if (bit_of(ok, m_chan)) done = 1;
      else if (m_age >= int'(tmo)) begin
        done = 1; m_fail = 1; m_fidx = m_chan;
      end else if (m_age < 65535) m_age++;
    end
    if (done) begin
      m_rr   = (m_chan + 1) % N;
      m_chan = -1;
      m_gap  = load;
    end
    if (en) m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  endtask

  // okmode: 0 noise on other channels only, 1 answer 2 cycles after request,
  // 2 random (sometimes hits the selected channel), 3 answer exactly at the timeout cycle
  task automatic cyc(input bit en, input logic [15:0] mask, input logic [15:0] tmo,
                     input logic [3:0] ce, input int okmode);
    logic [3:0] ok, selm, exp_req;
    selm = (m_chan >= 0) ? 4'(1 << m_chan) : 4'h0;
    case (okmode)
      1:       ok = (m_chan >= 0 && m_age == 1) ? selm : 4'h0;
      2:       ok = 4'($urandom) & (($urandom_range(0, 3) == 0) ? 4'hF : ~selm);
      3:       ok = ((m_chan >= 0 && m_age == int'(tmo)) ? selm : 4'h0) | (4'($urandom) & ~selm);
      default: ok = 4'($urandom) & ~selm;
    endcase
    en_i = en; wait_mask_i = mask; timeout_cyc_i = tmo; chan_en_i = ce; ping_ok_i = ok;
    model_step(en, mask, tmo, ce, ok);
    @(negedge clk_i);
    exp_req = (m_chan >= 0) ? 4'(1 << m_chan) : 4'h0;
    chk("req", 32'(ping_req_o), 32'(exp_req));
    chk("busy", 32'(busy_o), 32'(m_active));
    chk("fail", 32'(ping_fail_o), 32'(m_fail));
    if (m_fail) chk("fail_idx", 32'(ping_fail_idx_o), 32'(m_fidx));
    chk("onehot0", 32'($onehot0(ping_req_o)), 32'd1);
    chk("fail_2cyc", 32'(ping_fail_o & prev_fail), 32'd0);
    if (ping_fail_o) begin
      fails_seen++;
      last_fidx = int'(ping_fail_idx_o);
    end
    if (ping_req_o != 4'h0 && prev_req == 4'h0) begin
      seq_q.push_back(ping_req_o);
      if (gap_chk) chk("gap_range", 32'(gap_len >= 1 && gap_len <= 16), 32'd1);
      gap_len = 0;
    end
    if (!busy_o) gap_len = 0;
    else if (ping_req_o == 4'h0) gap_len++;
    prev_req  = ping_req_o;
    prev_fail = ping_fail_o;
  endtask

  // Called at a negedge; checks that outputs clear asynchronously, before any clock edge.
  task automatic do_reset();
    rst_i = 1'b1; en_i = 1'b0; ping_ok_i = 4'h0;
    #1;
    chk("rst_req", 32'(ping_req_o), 32'd0);
    chk("rst_fail", 32'(ping_fail_o), 32'd0);
    chk("rst_idx", 32'(ping_fail_idx_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    prev_req = 4'h0; prev_fail = 0; gap_len = 0; fails_seen = 0;
    seq_q.delete();
  endtask

  initial begin
    int req_cnt, ch;
    logic [15:0] mask, tmo;
    logic [3:0]  ce;
    rst_i = 1'b1; en_i = 1'b0; wait_mask_i = 16'h0; timeout_cyc_i = 16'h0;
    chan_en_i = 4'h0; ping_ok_i = 4'h0; gap_chk = 0; last_fidx = -1;
    @(negedge clk_i);
    do_reset();

    // round-robin over all channels, immediate gaps, answered after 2 cycles
    for (int i = 0; i < 200 && seq_q.size() < 5; i++) cyc(1, 16'h0, 16'd100, 4'hF, 1);
    chk("t1_count", 32'(seq_q.size()), 32'd5);
    for (int k = 0; k < seq_q.size() && k < 5; k++)
      chk("t1_seq", 32'(seq_q[k]), 32'(1 << (k % 4)));
    chk("t1_no_fail", 32'(fails_seen), 32'd0);

    // timeout on channel 2 with noise on the other channels
    @(negedge clk_i); do_reset();
    req_cnt = 0;
    for (int i = 0; i < 100 && fails_seen == 0; i++) begin
      cyc(1, 16'h0, 16'd5, 4'b0100, 0);
      if (ping_req_o == 4'b0100) req_cnt++;
    end
    chk("t2_req_cycles", 32'(req_cnt), 32'd6);
    chk("t2_fail_idx", 32'(last_fidx), 32'd2);

    // skip disabled channels starting from rr_ptr=1
    @(negedge clk_i); do_reset();
    for (int i = 0; i < 50 && !(seq_q.size() == 1 && m_chan < 0); i++) cyc(1, 16'h0, 16'd100, 4'b0001, 1);
    chk("t3_first", 32'(seq_q.size()), 32'd1);
    seq_q.delete();
    for (int i = 0; i < 50 && seq_q.size() < 2; i++) cyc(1, 16'h0, 16'd100, 4'b1001, 1);
    chk("t3_count", 32'(seq_q.size()), 32'd2);
    if (seq_q.size() >= 2) begin
      chk("t3_ch3", 32'(seq_q[0]), 32'b1000);
      chk("t3_ch0", 32'(seq_q[1]), 32'b0001);
    end
    for (int i = 0; i < 10; i++) cyc(1, 16'h0, 16'd100, 4'b0000, 1);
    seq_q.delete();
    for (int i = 0; i < 1000; i++) cyc(1, 16'h0, 16'd100, 4'b0000, 1);
    chk("t3_no_req", 32'(seq_q.size()), 32'd0);
    chk("t3_busy", 32'(busy_o), 32'd1);

    // ok arriving in the same cycle the timeout is reached
    @(negedge clk_i); do_reset();
    for (int i = 0; i < 80; i++) cyc(1, 16'h0, 16'd3, 4'hF, 3);
    chk("t4_pings", 32'(seq_q.size() >= 5), 32'd1);
    chk("t4_no_fail", 32'(fails_seen), 32'd0);

    // abort by en_i, re-enable keeps rr_ptr, then async reset mid-ping
    @(negedge clk_i); do_reset();
    for (int i = 0; i < 30 && seq_q.size() < 2; i++) cyc(1, 16'h0, 16'd100, 4'hF, 1);
    for (int i = 0; i < 10 && m_chan < 0; i++) cyc(1, 16'h0, 16'd100, 4'hF, 0);
    ch = m_chan;
    chk("t5_in_ping", 32'(ch), 32'd1);
    cyc(0, 16'h0, 16'd100, 4'hF, 0);
    chk("t5_req_off", 32'(ping_req_o), 32'd0);
    chk("t5_busy_off", 32'(busy_o), 32'd0);
    chk("t5_no_fail", 32'(ping_fail_o), 32'd0);
    seq_q.delete();
    for (int i = 0; i < 20 && seq_q.size() < 1; i++) cyc(1, 16'h0, 16'd100, 4'hF, 0);
    chk("t5_rr_kept", 32'(seq_q.size() > 0 ? seq_q[0] : 4'h0), 32'b0010);
    do_reset();

    // random gaps bounded by the mask, reproducible from the seed through the model
    @(negedge clk_i); do_reset();
    gap_chk = 1;
    for (int i = 0; i < 400; i++) cyc(1, 16'h000F, 16'd100, 4'hF, 1);
    gap_chk = 0;
    chk("t6_pings", 32'(seq_q.size() >= 15), 32'd1);

    // randomized traffic
    @(negedge clk_i); do_reset();
    mask = 16'h0; tmo = 16'd4; ce = 4'hF;
    for (int i = 0; i < 4000; i++) begin
      if (i % 60 == 0) begin
        case ($urandom_range(0, 3))
          0: mask = 16'h0000;
          1: mask = 16'h000F;
          2: mask = 16'h003F;
          default: mask = 16'($urandom) & 16'h001F;
        endcase
        tmo = 16'($urandom_range(0, 10));
        ce  = 4'($urandom);
      end
      if (i % 997 == 500 && m_chan >= 0) begin
        do_reset();
        chk("rand_rst_req", 32'(ping_req_o), 32'd0);
      end
      cyc($urandom_range(0, 39) != 0, mask, tmo, ce, 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
